vocab_writer: RTL and testbench

- Loads vocabulary entries into the vocab memory that the matcher scans.
- Accepts words on a valid/ready stream and writes them to consecutive addresses from a base address.
- Closes the list with the null entry (all-zero word) that the matcher treats as end-of-vocabulary.
- Reports the end address, the entry count and an overflow flag to control logic.

---
 rtl/vocab_pkg.sv | 22 ++
 rtl/vocab_addr_gen.sv | 44 ++++
 rtl/vocab_writer.sv | 209 ++++++++++++++++++++
 tb/tb_vocab_writer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vocab_pkg.sv
// Shared vocabulary definitions for the vocab writer and the matcher.
// The null entry (all-zero word) marks the end of a vocabulary list.
package vocab_pkg;

    localparam int DEF_ADDR_WIDTH  = 4;
    localparam int DEF_WORD_LENGTH = 3;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int VOCAB_WORD_W    = DEF_WORD_LENGTH * DEF_DATA_WIDTH;

    typedef logic [VOCAB_WORD_W-1:0] vocab_word_t;

    localparam vocab_word_t NULL_VOCAB = '0;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WRITE,
        TERM,
        DONE
    } writer_state_t;

endpackage

// File: rtl/vocab_addr_gen.sv
// Saturating address counter with load, increment, last-address flag and
// a count of increments since the last load.
module vocab_addr_gen
    import vocab_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_load_addr,
    input  logic                  i_inc,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_at_last,
    output logic [ADDR_WIDTH:0]   o_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  w_at_last;

    assign w_at_last = (r_addr == LAST_ADDR);

    // Load restarts the address and count; increments stop at the last address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_addr  <= i_load_addr;
            r_count <= '0;
        end else if (i_inc && !w_at_last) begin
            r_addr  <= r_addr + 1'b1;
            r_count <= r_count + 1'b1;
        end
    end

    assign o_addr    = r_addr;
    assign o_at_last = w_at_last;
    assign o_count   = r_count;

endmodule

// File: rtl/vocab_writer.sv
// Streams vocabulary words into consecutive memory addresses from a base
// address and closes the list with the null entry. The last address is
// always kept for the terminator, so excess words are dropped and flagged.
// Optional build macro VOCAB_CLEAR_EN zeroes base..top of memory before
// writing so stale entries past the new list can never alias.
module vocab_writer
    import vocab_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WORD_LENGTH = DEF_WORD_LENGTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [ADDR_WIDTH-1:0]             base_addr,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] in_word,
    input  logic                              in_last,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [WORD_LENGTH*DATA_WIDTH-1:0] mem_wdata,
    output logic                              busy,
    output logic                              done,
    output logic [ADDR_WIDTH-1:0]             end_addr,
    output logic [ADDR_WIDTH:0]               count,
    output logic                              vocab_overflow,
    output logic                              null_drop
);

    localparam int WW = WORD_LENGTH * DATA_WIDTH;

    writer_state_t r_state;
    writer_state_t w_next_state;

    logic                  w_accept;
    logic                  w_is_null;
    logic                  w_load;
    logic [ADDR_WIDTH-1:0] w_load_addr;
    logic                  w_inc;
    logic [ADDR_WIDTH-1:0] w_curr_addr;
    logic                  w_at_last;
    logic [ADDR_WIDTH:0]   w_count;

    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [WW-1:0]         r_mem_wdata;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_end_addr;
    logic                  r_overflow;
    logic                  r_null_drop;

`ifdef VOCAB_CLEAR_EN
    logic [ADDR_WIDTH-1:0] r_base;
`endif

    assign w_is_null = (in_word == '0);

    vocab_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_addr (w_load_addr),
        .i_inc       (w_inc),
        .o_addr      (w_curr_addr),
        .o_at_last   (w_at_last),
        .o_count     (w_count)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, stream handshake and address counter controls.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_load_addr  = base_addr;
        w_inc        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
`ifdef VOCAB_CLEAR_EN
                    w_next_state = CLEAR;
`else
                    w_next_state = WRITE;
`endif
                end
            end
`ifdef VOCAB_CLEAR_EN
            CLEAR: begin
                if (w_at_last) begin
                    w_load       = 1'b1;
                    w_load_addr  = r_base;
                    w_next_state = WRITE;
                end else begin
                    w_inc = 1'b1;
                end
            end
`endif
            WRITE: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (w_accept && !w_is_null && !w_at_last) begin
                    w_inc = 1'b1;
                end
                if (w_accept && in_last) begin
                    w_next_state = TERM;
                end
            end
            TERM: begin
                w_next_state = DONE;
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Registered memory port and status flags; strobes default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_end_addr  <= '0;
            r_overflow  <= 1'b0;
            r_null_drop <= 1'b0;
`ifdef VOCAB_CLEAR_EN
            r_base      <= '0;
`endif
        end else begin
            r_mem_we    <= 1'b0;
            r_done      <= 1'b0;
            r_null_drop <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy     <= 1'b1;
                        r_overflow <= 1'b0;
`ifdef VOCAB_CLEAR_EN
                        r_base     <= base_addr;
`endif
                    end
                end
`ifdef VOCAB_CLEAR_EN
                CLEAR: begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= w_curr_addr;
                    r_mem_wdata <= '0;
                end
`endif
                WRITE: begin
                    if (w_accept) begin
                        if (w_is_null) begin
                            r_null_drop <= 1'b1;
                        end else if (!w_at_last) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= w_curr_addr;
                            r_mem_wdata <= in_word;
                        end else begin
                            r_overflow  <= 1'b1;
                        end
                    end
                end
                TERM: begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= w_curr_addr;
                    r_mem_wdata <= '0;
                    r_end_addr  <= w_curr_addr;
                end
                DONE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_we         = r_mem_we;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;
    assign busy           = r_busy;
    assign done           = r_done;
    assign end_addr       = r_end_addr;
    assign count          = w_count;
    assign vocab_overflow = r_overflow;
    assign null_drop      = r_null_drop;

endmodule

// File: tb/tb_vocab_writer.sv
// Directed testbench for vocab_writer: loads short vocabularies and checks
// the resulting memory image, write counts and status outputs.
module tb_vocab_writer;

    localparam int AW = 4;
    localparam int WW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic          in_ready;
    logic [WW-1:0] in_word;
    logic          in_last;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic          busy;
    logic          done;
    logic [AW-1:0] end_addr;
    logic [AW:0]   count;
    logic          vocab_overflow;
    logic          null_drop;

    logic [WW-1:0] mem [16];
    int            weCount = 0;
    int            nullDropCount = 0;
    int            doneCount = 0;
    int            checks = 0;
    int            errors = 0;
    int            weBase;
    int            ndBase;
    int            dnBase;

    vocab_writer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .base_addr      (base_addr),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_word        (in_word),
        .in_last        (in_last),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .busy           (busy),
        .done           (done),
        .end_addr       (end_addr),
        .count          (count),
        .vocab_overflow (vocab_overflow),
        .null_drop      (null_drop)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Memory model plus counters of write strobes, null drops and done pulses.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            weCount       <= weCount + 1;
        end
        if (null_drop) nullDropCount <= nullDropCount + 1;
        if (done)      doneCount     <= doneCount + 1;
    end

    // Hard stop in case the directed sequence itself stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic doStart(input logic [AW-1:0] b);
        start     = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic applyStimulus(input logic [WW-1:0] w, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_word  = w;
        in_last  = last;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("acceptWithinBudget", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_word  = '0;
        in_last  = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (done !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("doneSeen", 32'(done), 32'd1);
        checkOutput("busyLowAtDone", 32'(busy), 32'd0);
    endtask

    // Directed stimulus sequence.
    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0;
        in_valid = 1'b0; in_word = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstMemWe", 32'(mem_we), 32'd0);
        checkOutput("rstInReady", 32'(in_ready), 32'd0);
        checkOutput("rstCount", 32'(count), 32'd0);
        checkOutput("rstEndAddr", 32'(end_addr), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] basic load");
        weBase = weCount; dnBase = doneCount;
        doStart(4'd0);
        checkOutput("basicBusy", 32'(busy), 32'd1);
        checkOutput("basicReady", 32'(in_ready), 32'd1);
        applyStimulus(24'h48656C, 1'b0);
        checkOutput("basicWe0", 32'(mem_we), 32'd1);
        checkOutput("basicAddr0", 32'(mem_addr), 32'd0);
        checkOutput("basicData0", 32'(mem_wdata), 32'h48656C);
        applyStimulus(24'h6C6F20, 1'b1);
        checkOutput("basicTermReady", 32'(in_ready), 32'd0);
        waitDone();
        checkOutput("basicMem0", 32'(mem[0]), 32'h48656C);
        checkOutput("basicMem1", 32'(mem[1]), 32'h6C6F20);
        checkOutput("basicMem2", 32'(mem[2]), 32'h000000);
        checkOutput("basicEnd", 32'(end_addr), 32'd2);
        checkOutput("basicCount", 32'(count), 32'd2);
        checkOutput("basicOvf", 32'(vocab_overflow), 32'd0);
        checkOutput("basicWrites", 32'(weCount - weBase), 32'd3);
        @(posedge clk); #1;
        checkOutput("basicDoneLow", 32'(done), 32'd0);
        checkOutput("basicDonePulses", 32'(doneCount - dnBase), 32'd1);

        $display("[TB] backpressure and gaps");
        weBase = weCount;
        doStart(4'd0);
        @(posedge clk); #1;
        checkOutput("gapIdleWe", 32'(mem_we), 32'd0);
        applyStimulus(24'h48656C, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("gapIdleWe2", 32'(mem_we), 32'd0);
        applyStimulus(24'h6C6F20, 1'b1);
        waitDone();
        checkOutput("gapMem0", 32'(mem[0]), 32'h48656C);
        checkOutput("gapMem1", 32'(mem[1]), 32'h6C6F20);
        checkOutput("gapMem2", 32'(mem[2]), 32'h000000);
        checkOutput("gapWrites", 32'(weCount - weBase), 32'd3);

        $display("[TB] null drop and ignored start");
        weBase = weCount; ndBase = nullDropCount;
        doStart(4'd0);
        applyStimulus(24'h414243, 1'b0);
        applyStimulus(24'h000000, 1'b0);
        checkOutput("nullPulse", 32'(null_drop), 32'd1);
        checkOutput("nullNoWe", 32'(mem_we), 32'd0);
        start = 1'b1; base_addr = 4'd7;
        @(posedge clk); #1;
        start = 1'b0;
        applyStimulus(24'h444546, 1'b1);
        waitDone();
        checkOutput("nullMem0", 32'(mem[0]), 32'h414243);
        checkOutput("nullMem1", 32'(mem[1]), 32'h444546);
        checkOutput("nullMem2", 32'(mem[2]), 32'h000000);
        checkOutput("nullCount", 32'(count), 32'd2);
        checkOutput("nullEnd", 32'(end_addr), 32'd2);
        checkOutput("nullDrops", 32'(nullDropCount - ndBase), 32'd1);
        checkOutput("nullWrites", 32'(weCount - weBase), 32'd3);

        $display("[TB] overflow near top of memory");
        weBase = weCount;
        doStart(4'd13);
        applyStimulus(24'h111111, 1'b0);
        applyStimulus(24'h222222, 1'b0);
        applyStimulus(24'h333333, 1'b0);
        applyStimulus(24'h444444, 1'b0);
        applyStimulus(24'h555555, 1'b1);
        waitDone();
        checkOutput("ovfMem13", 32'(mem[13]), 32'h111111);
        checkOutput("ovfMem14", 32'(mem[14]), 32'h222222);
        checkOutput("ovfMem15", 32'(mem[15]), 32'h000000);
        checkOutput("ovfFlag", 32'(vocab_overflow), 32'd1);
        checkOutput("ovfCount", 32'(count), 32'd2);
        checkOutput("ovfEnd", 32'(end_addr), 32'd15);
        checkOutput("ovfWrites", 32'(weCount - weBase), 32'd3);

        $display("[TB] base at last address");
        weBase = weCount;
        doStart(4'd15);
        checkOutput("topOvfCleared", 32'(vocab_overflow), 32'd0);
        applyStimulus(24'h777777, 1'b1);
        waitDone();
        checkOutput("topMem15", 32'(mem[15]), 32'h000000);
        checkOutput("topOvf", 32'(vocab_overflow), 32'd1);
        checkOutput("topCount", 32'(count), 32'd0);
        checkOutput("topEnd", 32'(end_addr), 32'd15);
        checkOutput("topWrites", 32'(weCount - weBase), 32'd1);

        $display("[TB] reset mid-session");
        weBase = weCount;
        doStart(4'd0);
        applyStimulus(24'h999999, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstWe", 32'(mem_we), 32'd0);
        checkOutput("midRstReady", 32'(in_ready), 32'd0);
        checkOutput("midRstCount", 32'(count), 32'd0);
        checkOutput("midRstEnd", 32'(end_addr), 32'd0);
        checkOutput("midRstOvf", 32'(vocab_overflow), 32'd0);
        checkOutput("midRstDone", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midRstMem0", 32'(mem[0]), 32'h999999);
        checkOutput("midRstWrites", 32'(weCount - weBase), 32'd1);
        doStart(4'd4);
        applyStimulus(24'hABCDEF, 1'b1);
        waitDone();
        checkOutput("freshMem4", 32'(mem[4]), 32'hABCDEF);
        checkOutput("freshMem5", 32'(mem[5]), 32'h000000);
        checkOutput("freshEnd", 32'(end_addr), 32'd5);
        checkOutput("freshCount", 32'(count), 32'd1);

`ifdef VOCAB_CLEAR_EN
        $display("[TB] clear before write");
        weBase = weCount;
        doStart(4'd12);
        for (int i = 0; i < 4; i++) begin
            checkOutput("clrReadyLow", 32'(in_ready), 32'd0);
            checkOutput("clrBusy", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        checkOutput("clrReadyHigh", 32'(in_ready), 32'd1);
        applyStimulus(24'h123456, 1'b1);
        waitDone();
        checkOutput("clrMem12", 32'(mem[12]), 32'h123456);
        checkOutput("clrMem13", 32'(mem[13]), 32'h000000);
        checkOutput("clrMem14", 32'(mem[14]), 32'h000000);
        checkOutput("clrMem15", 32'(mem[15]), 32'h000000);
        checkOutput("clrWrites", 32'(weCount - weBase), 32'd6);
`endif

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
